// File: rtl/axis_trigger_ctrl.sv
// Trigger acquisition controller: arms on command, forwards accepted events to an
// AXI4-Stream sink with a dead time after each one, and counts accepted/dropped events.
module axis_trigger_ctrl #(
    parameter int AXIS_TDATA_WIDTH = 128,
    parameter int CNTR_WIDTH       = 32,
    parameter int DEAD_WIDTH       = 16
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        cfg_arm,
    input  logic                        cfg_abort,
    input  logic [CNTR_WIDTH-1:0]       cfg_limit,
    input  logic [DEAD_WIDTH-1:0]       cfg_deadtime,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [1:0]                  sts_state,
    output logic [CNTR_WIDTH-1:0]       sts_accepted,
    output logic [CNTR_WIDTH-1:0]       sts_dropped
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        DEADTIME = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [CNTR_WIDTH-1:0] CNT_ONE  = CNTR_WIDTH'(1);
    localparam logic [DEAD_WIDTH-1:0] DEAD_ONE = DEAD_WIDTH'(1);

    state_t                  state, state_next;
    logic [CNTR_WIDTH-1:0]   limit_q;
    logic [DEAD_WIDTH-1:0]   dead_q;
    logic [DEAD_WIDTH-1:0]   dead_cnt;
    logic [CNTR_WIDTH-1:0]   accepted;
    logic [CNTR_WIDTH-1:0]   dropped;
    logic [CNTR_WIDTH:0]     accepted_plus1;
    logic                    slot_free;
    logic                    capture;
    logic                    inc_acc;
    logic                    inc_drop;
    logic                    load_dead;
    logic                    clear_cnt;

    assign slot_free      = !m_axis_tvalid || m_axis_tready;
    // One extra bit so a saturated counter can never falsely match the limit.
    assign accepted_plus1 = {1'b0, accepted} + {1'b0, CNT_ONE};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        inc_acc    = 1'b0;
        inc_drop   = 1'b0;
        load_dead  = 1'b0;
        clear_cnt  = 1'b0;
        if (cfg_abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (cfg_arm) begin
                        state_next = ARMED;
                        clear_cnt  = 1'b1;
                    end
                end
                ARMED: begin
                    if (s_axis_tvalid) begin
                        if (slot_free) begin
                            capture = 1'b1;
                            inc_acc = 1'b1;
                            // Reaching the limit wins over entering dead time.
                            if (limit_q != '0 && accepted_plus1 == {1'b0, limit_q}) begin
                                state_next = DONE;
                            end else if (dead_q != '0) begin
                                state_next = DEADTIME;
                                load_dead  = 1'b1;
                            end
                        end else begin
                            inc_drop = 1'b1;
                        end
                    end
                end
                DEADTIME: begin
                    inc_drop = s_axis_tvalid;
                    if (dead_cnt == DEAD_ONE) begin
                        state_next = ARMED;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            limit_q  <= '0;
            dead_q   <= '0;
            dead_cnt <= '0;
            accepted <= '0;
            dropped  <= '0;
        end else begin
            if (clear_cnt) begin
                limit_q  <= cfg_limit;
                dead_q   <= cfg_deadtime;
                accepted <= '0;
                dropped  <= '0;
            end else begin
                if (inc_acc && accepted != '1) begin
                    accepted <= accepted + CNT_ONE;
                end
                if (inc_drop && dropped != '1) begin
                    dropped <= dropped + CNT_ONE;
                end
            end
            if (load_dead) begin
                dead_cnt <= dead_q;
            end else if (state == DEADTIME && dead_cnt != '0) begin
                dead_cnt <= dead_cnt - DEAD_ONE;
            end
        end
    end

    // Output holding register: a new capture overrides a same-cycle handshake.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
        end else if (capture) begin
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tvalid <= 1'b1;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    assign sts_state    = state;
    assign sts_accepted = accepted;
    assign sts_dropped  = dropped;

endmodule

// File: tb/tb_axis_trigger_ctrl.sv
// Directed self-checking bench for axis_trigger_ctrl; a narrow-counter instance
// exercises counter saturation.
module tb_axis_trigger_ctrl;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic         cfg_arm;
    logic         cfg_abort;
    logic [31:0]  cfg_limit;
    logic [15:0]  cfg_deadtime;
    logic [127:0] s_axis_tdata;
    logic         s_axis_tvalid;
    logic [127:0] m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic [1:0]   sts_state;
    logic [31:0]  sts_accepted;
    logic [31:0]  sts_dropped;

    logic [127:0] sat_tdata;
    logic         sat_tvalid;
    logic [1:0]   sat_state;
    logic [3:0]   sat_accepted;
    logic [3:0]   sat_dropped;

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    axis_trigger_ctrl dut (
        .aclk(aclk), .aresetn(aresetn), .cfg_arm(cfg_arm), .cfg_abort(cfg_abort),
        .cfg_limit(cfg_limit), .cfg_deadtime(cfg_deadtime),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .sts_state(sts_state),
        .sts_accepted(sts_accepted), .sts_dropped(sts_dropped)
    );

    axis_trigger_ctrl #(.AXIS_TDATA_WIDTH(128), .CNTR_WIDTH(4), .DEAD_WIDTH(16)) sat_dut (
        .aclk(aclk), .aresetn(aresetn), .cfg_arm(cfg_arm), .cfg_abort(cfg_abort),
        .cfg_limit(cfg_limit[3:0]), .cfg_deadtime(cfg_deadtime),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .m_axis_tdata(sat_tdata), .m_axis_tvalid(sat_tvalid),
        .m_axis_tready(m_axis_tready), .sts_state(sat_state),
        .sts_accepted(sat_accepted), .sts_dropped(sat_dropped)
    );

    function automatic logic [127:0] mk_word(input int i);
        logic [62:0] ts;
        logic [63:0] dat;
        ts  = 63'(i * 1000 + 7);
        dat = 64'hA5A5_0000_0000_0000 ^ 64'(i * 3 + 1);
        return {ts, 1'b1, dat};
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic arm(input logic [31:0] lim, input logic [15:0] dt);
        cfg_arm = 1'b1; cfg_limit = lim; cfg_deadtime = dt;
        tick();
        cfg_arm = 1'b0;
    endtask

    task automatic abort();
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0; cfg_arm = 1'b0; cfg_abort = 1'b0; cfg_limit = '0; cfg_deadtime = '0;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
        repeat (2) tick();
        checks++; if (sts_state !== 2'd0) begin errors++; $display("[TB] FAIL reset_state got %0d expected 0", sts_state); end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tvalid got %b expected 0", m_axis_tvalid); end
        checks++; if (m_axis_tdata !== 128'h0) begin errors++; $display("[TB] FAIL reset_tdata got %h expected 0", m_axis_tdata); end
        checks++; if (sts_accepted !== 32'd0 || sts_dropped !== 32'd0) begin errors++; $display("[TB] FAIL reset_counters got %0d/%0d expected 0/0", sts_accepted, sts_dropped); end
        aresetn = 1'b1;
        tick();
    endtask

    task automatic test_limit();
        m_axis_tready = 1'b1;
        arm(32'd3, 16'd0);
        checks++; if (sts_state !== 2'd1) begin errors++; $display("[TB] FAIL limit_armed got %0d expected 1", sts_state); end
        for (int i = 0; i < 5; i++) begin
            s_axis_tvalid = 1'b1; s_axis_tdata = mk_word(i);
            tick();
            checks++; if (m_axis_tvalid !== (i < 3)) begin errors++; $display("[TB] FAIL limit_tvalid[%0d] got %b expected %b", i, m_axis_tvalid, (i < 3)); end
            if (i < 3) begin
                checks++; if (m_axis_tdata !== mk_word(i)) begin errors++; $display("[TB] FAIL limit_tdata[%0d] got %h expected %h", i, m_axis_tdata, mk_word(i)); end
            end
        end
        s_axis_tvalid = 1'b0;
        checks++; if (sts_accepted !== 32'd3) begin errors++; $display("[TB] FAIL limit_accepted got %0d expected 3", sts_accepted); end
        checks++; if (sts_dropped !== 32'd0) begin errors++; $display("[TB] FAIL limit_dropped got %0d expected 0", sts_dropped); end
        checks++; if (sts_state !== 2'd3) begin errors++; $display("[TB] FAIL limit_done got %0d expected 3", sts_state); end
    endtask

    task automatic test_deadtime();
        logic [1:0] exp_state;
        m_axis_tready = 1'b1;
        arm(32'd0, 16'd4);
        for (int c = 0; c < 20; c++) begin
            s_axis_tvalid = 1'b1; s_axis_tdata = mk_word(100 + c);
            tick();
            exp_state = (c % 5 == 4) ? 2'd1 : 2'd2;
            checks++; if (m_axis_tvalid !== (c % 5 == 0)) begin errors++; $display("[TB] FAIL dead_tvalid[%0d] got %b expected %b", c, m_axis_tvalid, (c % 5 == 0)); end
            checks++; if (sts_state !== exp_state) begin errors++; $display("[TB] FAIL dead_state[%0d] got %0d expected %0d", c, sts_state, exp_state); end
            if (c % 5 == 0) begin
                checks++; if (m_axis_tdata !== mk_word(100 + c)) begin errors++; $display("[TB] FAIL dead_tdata[%0d] got %h expected %h", c, m_axis_tdata, mk_word(100 + c)); end
            end
        end
        s_axis_tvalid = 1'b0;
        checks++; if (sts_accepted !== 32'd4) begin errors++; $display("[TB] FAIL dead_accepted got %0d expected 4", sts_accepted); end
        checks++; if (sts_dropped !== 32'd16) begin errors++; $display("[TB] FAIL dead_dropped got %0d expected 16", sts_dropped); end
    endtask

    task automatic test_backpressure();
        abort();
        m_axis_tready = 1'b0;
        arm(32'd0, 16'd0);
        for (int i = 0; i < 3; i++) begin
            s_axis_tvalid = 1'b1; s_axis_tdata = mk_word(200 + i);
            tick();
            checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== mk_word(200)) begin errors++; $display("[TB] FAIL bp_hold[%0d] got %b/%h expected 1/%h", i, m_axis_tvalid, m_axis_tdata, mk_word(200)); end
        end
        s_axis_tvalid = 1'b0;
        checks++; if (sts_accepted !== 32'd1 || sts_dropped !== 32'd2) begin errors++; $display("[TB] FAIL bp_counters got %0d/%0d expected 1/2", sts_accepted, sts_dropped); end
        m_axis_tready = 1'b1;
        tick();
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL bp_drain got %b expected 0", m_axis_tvalid); end
    endtask

    task automatic test_back_to_back();
        abort();
        m_axis_tready = 1'b1;
        arm(32'd0, 16'd0);
        for (int i = 0; i < 6; i++) begin
            s_axis_tvalid = 1'b1; s_axis_tdata = mk_word(300 + i);
            tick();
            checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== mk_word(300 + i)) begin errors++; $display("[TB] FAIL b2b[%0d] got %b/%h expected 1/%h", i, m_axis_tvalid, m_axis_tdata, mk_word(300 + i)); end
        end
        s_axis_tvalid = 1'b0;
        tick();
        checks++; if (sts_accepted !== 32'd6 || sts_dropped !== 32'd0) begin errors++; $display("[TB] FAIL b2b_counters got %0d/%0d expected 6/0", sts_accepted, sts_dropped); end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle_tvalid got %b expected 0", m_axis_tvalid); end
    endtask

    task automatic test_arm_abort();
        cfg_arm = 1'b1; cfg_abort = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = mk_word(400);
        tick();
        cfg_arm = 1'b0; cfg_abort = 1'b0;
        checks++; if (sts_state !== 2'd0) begin errors++; $display("[TB] FAIL abort_wins got %0d expected 0", sts_state); end
        checks++; if (sts_accepted !== 32'd6 || m_axis_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL abort_retain got %0d/%b expected 6/0", sts_accepted, m_axis_tvalid); end
        tick();
        s_axis_tvalid = 1'b0;
        checks++; if (sts_dropped !== 32'd0 || m_axis_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL idle_ignore got %0d/%b expected 0/0", sts_dropped, m_axis_tvalid); end
        arm(32'd2, 16'd0);
        cfg_limit = 32'd0;
        checks++; if (sts_state !== 2'd1 || sts_accepted !== 32'd0 || sts_dropped !== 32'd0) begin errors++; $display("[TB] FAIL rearm got %0d/%0d/%0d expected 1/0/0", sts_state, sts_accepted, sts_dropped); end
        for (int i = 0; i < 3; i++) begin
            s_axis_tvalid = 1'b1; s_axis_tdata = mk_word(410 + i);
            tick();
        end
        s_axis_tvalid = 1'b0;
        checks++; if (sts_state !== 2'd3 || sts_accepted !== 32'd2) begin errors++; $display("[TB] FAIL latched_limit got %0d/%0d expected 3/2", sts_state, sts_accepted); end
        arm(32'd0, 16'd0);
        m_axis_tready = 1'b0; s_axis_tvalid = 1'b1; s_axis_tdata = mk_word(420);
        tick();
        s_axis_tvalid = 1'b0;
        abort();
        checks++; if (sts_state !== 2'd0 || m_axis_tvalid !== 1'b1 || m_axis_tdata !== mk_word(420)) begin errors++; $display("[TB] FAIL abort_pending got %0d/%b/%h expected 0/1/%h", sts_state, m_axis_tvalid, m_axis_tdata, mk_word(420)); end
        m_axis_tready = 1'b1;
        tick();
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL abort_drain got %b expected 0", m_axis_tvalid); end
    endtask

    task automatic test_limit_dead();
        m_axis_tready = 1'b1;
        arm(32'd1, 16'd5);
        s_axis_tvalid = 1'b1; s_axis_tdata = mk_word(500);
        tick();
        checks++; if (sts_state !== 2'd3 || sts_accepted !== 32'd1) begin errors++; $display("[TB] FAIL limit_over_dead got %0d/%0d expected 3/1", sts_state, sts_accepted); end
        tick();
        s_axis_tvalid = 1'b0;
        checks++; if (sts_dropped !== 32'd0) begin errors++; $display("[TB] FAIL done_ignore got %0d expected 0", sts_dropped); end
    endtask

    task automatic test_saturation();
        m_axis_tready = 1'b0;
        arm(32'd0, 16'd0);
        for (int i = 0; i < 20; i++) begin
            s_axis_tvalid = 1'b1; s_axis_tdata = mk_word(600 + i);
            tick();
        end
        s_axis_tvalid = 1'b0;
        checks++; if (sat_dropped !== 4'hF || sat_accepted !== 4'd1) begin errors++; $display("[TB] FAIL sat_dropped got %0d/%0d expected 15/1", sat_dropped, sat_accepted); end
        checks++; if (sts_dropped !== 32'd19) begin errors++; $display("[TB] FAIL wide_dropped got %0d expected 19", sts_dropped); end
        abort();
        m_axis_tready = 1'b1;
        arm(32'd0, 16'd0);
        for (int i = 0; i < 20; i++) begin
            s_axis_tvalid = 1'b1; s_axis_tdata = mk_word(700 + i);
            tick();
        end
        s_axis_tvalid = 1'b0;
        checks++; if (sat_accepted !== 4'hF || sat_dropped !== 4'd0) begin errors++; $display("[TB] FAIL sat_accepted got %0d/%0d expected 15/0", sat_accepted, sat_dropped); end
        checks++; if (sts_accepted !== 32'd20) begin errors++; $display("[TB] FAIL wide_accepted got %0d expected 20", sts_accepted); end
    endtask

    task automatic test_reset_mid();
        m_axis_tready = 1'b0; s_axis_tvalid = 1'b1; s_axis_tdata = mk_word(800);
        tick();
        s_axis_tvalid = 1'b0;
        checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_tvalid got %b expected 1", m_axis_tvalid); end
        #1 aresetn = 1'b0;
        #1;
        checks++; if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 128'h0) begin errors++; $display("[TB] FAIL async_reset_out got %b/%h expected 0/0", m_axis_tvalid, m_axis_tdata); end
        checks++; if (sts_state !== 2'd0 || sts_accepted !== 32'd0 || sts_dropped !== 32'd0) begin errors++; $display("[TB] FAIL async_reset_sts got %0d/%0d/%0d expected 0/0/0", sts_state, sts_accepted, sts_dropped); end
        tick();
        aresetn = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_limit();
        test_deadtime();
        test_backpressure();
        test_back_to_back();
        test_arm_abort();
        test_limit_dead();
        test_saturation();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
